seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the team's hex-to-7-segment driver. Snoops the active-low anode and segment bus of a 4-digit multiplexed display and reconstructs the four hex nibbles being shown.
- Used for board-level loopback self-check of the multiplier result display, and as a bench monitor in simulation.
- Sequential: per-sample stability filter, per-digit capture, frame assembly with completion strobe, and a staleness timeout.

---
 rtl/seg7_scan_capture.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: snoops the active-low anode/segment/dp bus of a 4-digit
// multiplexed 7-segment display and rebuilds the four hex nibbles shown.
// A stability filter qualifies each {an,seg,dp} sample. Each stable one-hot
// digit is decoded into a staging slot. When all four slots have been seen,
// the frame is published with a one-cycle frame_done pulse. A staleness
// timeout drops all valid flags when no capture happens for too long.
// Optional feature macro: SEG7_CAP_SYNC_EN adds a 2-flop input synchroniser
// in front of the filter, which delays all capture timing by two cycles.
module seg7_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_seen,
  output logic        frame_done,
  output logic        pat_err
);

  localparam logic [7:0]  STABLE_V  = 8'(STABLE_CYCLES);
  localparam logic [23:0] TIMEOUT_V = 24'(TIMEOUT_CYCLES);

  // Filter input sample packed as {an, seg, dp}
  logic [11:0] smp;

`ifdef SEG7_CAP_SYNC_EN
  logic [11:0] sync1_q, sync2_q;

  // Two-flop synchroniser; resets to all ones, which reads as "display off"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an, seg, dp};
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q;
`else
  assign smp = {an, seg, dp};
`endif

  logic [3:0] smp_an;
  logic [6:0] smp_seg;
  logic       smp_dp;

  assign smp_an  = smp[11:8];
  assign smp_seg = smp[7:1];
  assign smp_dp  = smp[0];

  // Exactly one anode driven low; blanking gaps and multi-digit glitches fail this
  logic an_onehot;
  assign an_onehot = (smp_an == 4'b1110) || (smp_an == 4'b1101) ||
                     (smp_an == 4'b1011) || (smp_an == 4'b0111);

  logic [3:0] dec_nib;
  logic       dec_known;
  logic       dec_blank;

  // Segment pattern to nibble decode; all-dark is a blank digit, not an error
  always_comb begin
    dec_nib   = 4'h0;
    dec_known = 1'b1;
    dec_blank = 1'b0;
    case (smp_seg)
      7'b0000001: dec_nib = 4'h0;
      7'b1001111: dec_nib = 4'h1;
      7'b0010010: dec_nib = 4'h2;
      7'b0000110: dec_nib = 4'h3;
      7'b1001100: dec_nib = 4'h4;
      7'b0100100: dec_nib = 4'h5;
      7'b0100000: dec_nib = 4'h6;
      7'b0001111: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0000100: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b1100000: dec_nib = 4'hB;
      7'b0110001: dec_nib = 4'hC;
      7'b1000010: dec_nib = 4'hD;
      7'b0110000: dec_nib = 4'hE;
      7'b0111000: dec_nib = 4'hF;
      7'b1111111: begin
        dec_known = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_known = 1'b0;
    endcase
  end

  logic [11:0] prev_q, prev_d;
  logic [7:0]  stab_q, stab_d;
  logic [23:0] to_q, to_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] stg_nib_q, stg_nib_d;
  logic [3:0]  stg_val_q, stg_val_d;
  logic [3:0]  stg_dp_q, stg_dp_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  digit_valid_q, digit_valid_d;
  logic [3:0]  dp_seen_q, dp_seen_d;
  logic        frame_done_q, frame_done_d;
  logic        pat_err_q, pat_err_d;

  logic       same;
  logic       capture;
  logic [3:0] cap_mask;

  // Stability filter, capture, frame publish, timeout and error flag next-state
  always_comb begin
    same    = (smp == prev_q);
    prev_d  = smp;

    if (!same)                  stab_d = 8'd1;
    else if (stab_q == STABLE_V) stab_d = stab_q;
    else                        stab_d = stab_q + 8'd1;

    // Fire once when the count first lands on the threshold; a fresh sample
    // reloading to 1 also counts as "first" when the threshold is 1
    capture  = (stab_d == STABLE_V) && (!same || (stab_q != STABLE_V)) && an_onehot;
    cap_mask = capture ? ~smp_an : 4'b0000;

    stg_nib_d     = stg_nib_q;
    stg_val_d     = stg_val_q;
    stg_dp_d      = stg_dp_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    digit_valid_d = digit_valid_q;
    dp_seen_d     = dp_seen_q;
    frame_done_d  = 1'b0;
    to_d          = to_q;

    // Publish uses the staging contents from before this cycle's capture
    if (seen_q == 4'hF) begin
      digits_d      = stg_nib_q;
      digit_valid_d = stg_val_q;
      dp_seen_d     = stg_dp_q;
      frame_done_d  = 1'b1;
      seen_d        = 4'h0;
    end

    for (int k = 0; k < 4; k++) begin
      if (cap_mask[k]) begin
        stg_nib_d[4*k +: 4] = dec_nib;
        stg_val_d[k]        = dec_known;
        stg_dp_d[k]         = ~smp_dp;
        seen_d[k]           = 1'b1;
      end
    end

    if (capture) begin
      to_d = 24'd0;
    end else if (to_q != TIMEOUT_V) begin
      to_d = to_q + 24'd1;
      if (to_d == TIMEOUT_V) begin
        digit_valid_d = 4'h0;
        seen_d        = 4'h0;
      end
    end

    if (capture && !dec_known && !dec_blank) pat_err_d = 1'b1;
    else if (err_clr)                        pat_err_d = 1'b0;
    else                                     pat_err_d = pat_err_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q        <= '0;
      stab_q        <= '0;
      to_q          <= '0;
      seen_q        <= '0;
      stg_nib_q     <= '0;
      stg_val_q     <= '0;
      stg_dp_q      <= '0;
      digits_q      <= '0;
      digit_valid_q <= '0;
      dp_seen_q     <= '0;
      frame_done_q  <= 1'b0;
      pat_err_q     <= 1'b0;
    end else begin
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      to_q          <= to_d;
      seen_q        <= seen_d;
      stg_nib_q     <= stg_nib_d;
      stg_val_q     <= stg_val_d;
      stg_dp_q      <= stg_dp_d;
      digits_q      <= digits_d;
      digit_valid_q <= digit_valid_d;
      dp_seen_q     <= dp_seen_d;
      frame_done_q  <= frame_done_d;
      pat_err_q     <= pat_err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = digit_valid_q;
  assign dp_seen     = dp_seen_q;
  assign frame_done  = frame_done_q;
  assign pat_err     = pat_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans with literal expectations plus
// a randomized scan phase, all cross-checked every cycle against a
// behavioural display-reader model.
module tb_seg7_scan_capture;

  localparam int STABLE = 4;
  localparam int TO     = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  dp_seen;
  logic        frame_done;
  logic        pat_err;

  // Clock and reset block
  always #5 clk = ~clk;

  seg7_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dp(dp), .err_clr(err_clr),
    .digits(digits), .digit_valid(digit_valid), .dp_seen(dp_seen),
    .frame_done(frame_done), .pat_err(pat_err)
  );

  // Segment patterns for nibbles 0..F (active low, a..g)
  logic [6:0] pat_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int checks   = 0;
  int failures = 0;
  int fd_count = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a reader of the display should have reconstructed
  logic [11:0] m_prev, m_p1, m_p2;
  int          m_run, m_since;
  logic [3:0]  m_seen;
  logic [3:0]  m_nib [4];
  logic        m_val [4];
  logic        m_dp  [4];
  logic [15:0] e_digits;
  logic [3:0]  e_valid, e_dp;
  logic        e_fd, e_err;

  always @(posedge clk or negedge rst_n) begin : model_blk
    logic [11:0] s;
    int          nz, pos, found;
    bit          cap, err_set;
    if (!rst_n) begin
      m_prev = '0; m_p1 = '1; m_p2 = '1; m_run = 0; m_since = 0; m_seen = '0;
      for (int k = 0; k < 4; k++) begin m_nib[k] = '0; m_val[k] = 0; m_dp[k] = 0; end
      e_digits = '0; e_valid = '0; e_dp = '0; e_fd = 0; e_err = 0;
    end else begin
`ifdef SEG7_CAP_SYNC_EN
      s = m_p2; m_p2 = m_p1; m_p1 = {an, seg, dp};
`else
      s = {an, seg, dp};
`endif
      if (s == m_prev) m_run++; else m_run = 1;
      m_prev = s;
      nz = 0; pos = 0;
      for (int k = 0; k < 4; k++) if (!s[8+k]) begin nz++; pos = k; end
      cap = (m_run == STABLE) && (nz == 1);
      err_set = 0;
      e_fd = 0;
      if (m_seen == 4'hF) begin
        for (int k = 0; k < 4; k++) begin
          e_digits[4*k +: 4] = m_nib[k]; e_valid[k] = m_val[k]; e_dp[k] = m_dp[k];
        end
        e_fd = 1; m_seen = '0;
      end
      if (cap) begin
        found = -1;
        for (int i = 0; i < 16; i++) if (pat_tab[i] == s[7:1]) found = i;
        m_nib[pos] = (found >= 0) ? 4'(found) : 4'h0;
        m_val[pos] = (found >= 0);
        m_dp[pos]  = ~s[0];
        m_seen[pos] = 1'b1;
        if (found < 0 && s[7:1] != 7'h7F) err_set = 1;
        m_since = 0;
      end else begin
        m_since++;
        if (m_since == TO) begin e_valid = '0; m_seen = '0; end
      end
      if (err_set) e_err = 1; else if (err_clr) e_err = 0;
    end
  end

  // Scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_on) begin
      check("digits", digits, e_digits);
      check("digit_valid", 16'(digit_valid), 16'(e_valid));
      check("dp_seen", 16'(dp_seen), 16'(e_dp));
      check("frame_done", 16'(frame_done), 16'(e_fd));
      check("pat_err", 16'(pat_err), 16'(e_err));
      if (frame_done) fd_count++;
    end
  end

  // Driver tasks
  task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a; seg = s; dp = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    show(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_fd(input string name, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s actual=no_frame_done expected=frame_done within %0d cycles", name, budget);
    end
  endtask

  int f0;

  initial begin
    rst_n = 1'b0; an = 4'hF; seg = 7'h7F; dp = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cmp_on = 1'b1;

    // Reset state
    check("rst_digits", digits, 16'h0);
    check("rst_valid", 16'(digit_valid), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    check("rst_pat_err", 16'(pat_err), 16'h0);

    // Scan 3,2,1,0
    f0 = fd_count;
    show(4'b0111, 7'b0000110, 1'b1, 8);
    show(4'b1011, 7'b0010010, 1'b1, 8);
    show(4'b1101, 7'b1001111, 1'b1, 8);
    show(4'b1110, 7'b0000001, 1'b1, 8);
    blank(4);
    check("t1_frames", 16'(fd_count - f0), 16'd1);
    check("t1_digits", digits, 16'h3210);
    check("t1_valid", 16'(digit_valid), 16'hF);
    check("t1_pat_err", 16'(pat_err), 16'h0);

    // A,b,C,d with decimal point on an[2]
    show(4'b0111, 7'b0001000, 1'b1, 8);
    show(4'b1011, 7'b1100000, 1'b0, 8);
    show(4'b1101, 7'b0110001, 1'b1, 8);
    show(4'b1110, 7'b1000010, 1'b1, 8);
    blank(4);
    check("t2_digits", digits, 16'hABCD);
    check("t2_dp_seen", 16'(dp_seen), 16'h4);

    // Bouncing segments never settle long enough to capture
    f0 = fd_count;
    for (int i = 0; i < 5; i++) begin
      show(4'b1110, 7'b0000001, 1'b1, 2);
      show(4'b1110, 7'b1001111, 1'b1, 2);
    end
    check("t3_no_frame", 16'(fd_count - f0), 16'd0);
    show(4'b1110, 7'b0000000, 1'b1, 4);
    show(4'b0111, 7'b1001111, 1'b1, 8);
    show(4'b1011, 7'b0010010, 1'b1, 8);
    show(4'b1101, 7'b0000110, 1'b1, 8);
    blank(4);
    check("t3_frames", 16'(fd_count - f0), 16'd1);
    check("t3_digits", digits, 16'h1238);

    // Unknown pattern on digit 1
    show(4'b1110, 7'b0001111, 1'b1, 8);
    show(4'b1101, 7'b1111110, 1'b1, 8);
    show(4'b1011, 7'b0100100, 1'b1, 8);
    show(4'b0111, 7'b1001100, 1'b1, 8);
    blank(4);
    check("t4_pat_err", 16'(pat_err), 16'h1);
    check("t4_valid", 16'(digit_valid), 16'hD);
    check("t4_digits", digits, 16'h4507);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", 16'(pat_err), 16'h0);

    // Non-one-hot anodes and gaps leave frame progress alone; then timeout
    f0 = fd_count;
    show(4'b0111, 7'b0000001, 1'b1, 8);
    show(4'b1011, 7'b1001111, 1'b1, 8);
    show(4'b1100, 7'b0010010, 1'b1, 8);
    blank(8);
    show(4'b1101, 7'b0010010, 1'b1, 8);
    show(4'b1110, 7'b0000110, 1'b1, 4);
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    wait_fd("t5_frame", 10);
    check("t5_digits", digits, 16'h0123);
    repeat (98) @(negedge clk);
    check("t5_valid_before_to", 16'(digit_valid), 16'hF);
    @(negedge clk);
    check("t5_valid_after_to", 16'(digit_valid), 16'h0);
    check("t5_digits_kept", digits, 16'h0123);
    check("t5_frames", 16'(fd_count - f0), 16'd1);

    // Reset mid-frame discards partial progress
    show(4'b0111, 7'b1001100, 1'b1, 8);
    show(4'b1011, 7'b0100100, 1'b1, 8);
    show(4'b1101, 7'b0100000, 1'b1, 8);
    do_reset();
    check("t6_rst_digits", digits, 16'h0);
    f0 = fd_count;
    show(4'b0111, 7'b1001100, 1'b1, 8);
    show(4'b1011, 7'b0100100, 1'b1, 8);
    show(4'b1101, 7'b0100000, 1'b1, 8);
    show(4'b1110, 7'b0001111, 1'b1, 8);
    blank(4);
    check("t6_frames", 16'(fd_count - f0), 16'd1);
    check("t6_digits", digits, 16'h4567);

    // Randomized scanning checked by the model every cycle
    for (int si = 0; si < 320; si++) begin
      int r;
      r = $urandom_range(0, 19);
      if (si == 160) do_reset();
      if (r == 0) begin
        err_clr = 1'b0;
        blank(120);
      end else begin
        int rs;
        case ($urandom_range(0, 9))
          7:       an = 4'hF;
          8:       an = 4'($urandom_range(0, 15));
          default: an = ~(4'b0001 << $urandom_range(0, 3));
        endcase
        rs = $urandom_range(0, 13);
        if (rs < 12)       seg = pat_tab[$urandom_range(0, 15)];
        else if (rs == 12) seg = 7'h7F;
        else               seg = 7'($urandom_range(0, 127));
        dp = 1'($urandom_range(0, 1));
        err_clr = ($urandom_range(0, 7) == 0);
        repeat ($urandom_range(1, 7)) @(negedge clk);
      end
    end
    err_clr = 1'b0;
    blank(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
